// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS-style control FSM with parameterised memory wait
// Optional OVERFLOW_EXC_EN: signed overflow on add/sub/addi raises the exception sequence.
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic [5:0] Loads,
  output logic       wr,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [7:0] Estado
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_MEM_ADDR   = 4'd4,
    S_LW_WAIT    = 4'd5,
    S_LW_WB      = 4'd6,
    S_SW_WRITE   = 4'd7,
    S_R_EXEC     = 4'd8,
    S_R_WB       = 4'd9,
    S_ADDI_EXEC  = 4'd10,
    S_ADDI_WB    = 4'd11,
    S_BRANCH     = 4'd12,
    S_JUMP       = 4'd13,
    S_EXC_EPC    = 4'd14,
    S_EXC_VEC    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] CNT_LAST = 2'(MEM_WAIT - 1);

`ifdef OVERFLOW_EXC_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  // Load strobe bit positions within Loads
  localparam int L_PC = 5, L_MDR = 4, L_A = 3, L_B = 2, L_ALUOUT = 1, L_EPC = 0;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       cnt_last;
  logic       ovf_trap;
  logic       funct_ok;
  logic       funct_arith;
  logic [2:0] funct_op;

  assign cnt_last = (cnt == CNT_LAST);
  assign ovf_trap = OVF_EN & Overflow;
  assign Estado   = {4'd0, state};

  always_comb begin
    funct_ok    = 1'b1;
    funct_arith = 1'b0;
    funct_op    = 3'b000;
    case (Funct)
      6'h20:   begin funct_op = 3'b000; funct_arith = 1'b1; end
      6'h22:   begin funct_op = 3'b001; funct_arith = 1'b1; end
      6'h24:   funct_op = 3'b010;
      6'h25:   funct_op = 3'b011;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_RESET;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter defaults to zero so every entry into a wait state starts clean
  always_comb begin
    state_next = state;
    cnt_next   = 2'd0;
    Loads      = 6'd0;
    wr         = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    PCSource   = 2'b00;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        ALUSrcB = 2'b01;
        if (cnt_last) begin
          IRWrite     = 1'b1;
          Loads[L_PC] = 1'b1;
          state_next  = S_DECODE;
        end else begin
          cnt_next = cnt + 2'd1;
        end
      end
      S_DECODE: begin
        Loads[L_A]      = 1'b1;
        Loads[L_B]      = 1'b1;
        Loads[L_ALUOUT] = 1'b1;
        ALUSrcB         = 2'b11;
        case (Opcode)
          OP_RTYPE:      state_next = S_R_EXEC;
          OP_ADDI:       state_next = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          default:       state_next = S_EXC_EPC;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA         = 1'b1;
        ALUSrcB         = 2'b10;
        Loads[L_ALUOUT] = 1'b1;
        state_next      = (Opcode == OP_LW) ? S_LW_WAIT : S_SW_WRITE;
      end
      S_LW_WAIT: begin
        IorD = 1'b1;
        if (cnt_last) begin
          Loads[L_MDR] = 1'b1;
          state_next   = S_LW_WB;
        end else begin
          cnt_next = cnt + 2'd1;
        end
      end
      S_LW_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = S_FETCH;
      end
      S_SW_WRITE: begin
        IorD       = 1'b1;
        wr         = 1'b1;
        state_next = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA         = 1'b1;
        ALUOp           = funct_op;
        Loads[L_ALUOUT] = 1'b1;
        if (!funct_ok || (funct_arith && ovf_trap)) state_next = S_EXC_EPC;
        else                                       state_next = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA         = 1'b1;
        ALUSrcB         = 2'b10;
        Loads[L_ALUOUT] = 1'b1;
        state_next      = ovf_trap ? S_EXC_EPC : S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCSource    = 2'b01;
        Loads[L_PC] = (Opcode == OP_BEQ) ? Zero : ~Zero;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        PCSource    = 2'b10;
        Loads[L_PC] = 1'b1;
        state_next  = S_FETCH;
      end
      S_EXC_EPC: begin
        ALUSrcB      = 2'b01;
        ALUOp        = 3'b001;
        Loads[L_EPC] = 1'b1;
        state_next   = S_EXC_VEC;
      end
      S_EXC_VEC: begin
        PCSource    = 2'b11;
        Loads[L_PC] = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench: per-instruction cycle model vs control_unit outputs
module tb_control_unit;
  localparam int MW = 2;
`ifdef OVERFLOW_EXC_EN
  localparam bit OVF_EXC = 1'b1;
`else
  localparam bit OVF_EXC = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Opcode = 6'd0, Funct = 6'd0;
  logic       Zero = 1'b0, Overflow = 1'b0;
  logic [5:0] Loads;
  logic       wr, IRWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [7:0] Estado;

  control_unit #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .Loads(Loads), .wr(wr), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Estado(Estado)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] est;
    logic [5:0] loads;
    logic       wr, irw, regw, iord, regdst, memtoreg, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } obs_t;

  obs_t act;
  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  always_comb act = {Estado, Loads, wr, IRWrite, RegWrite, IorD, RegDst, MemtoReg,
                     ALUSrcA, ALUSrcB, ALUOp, PCSource};

  function automatic obs_t blank(int est);
    obs_t o;
    o     = '0;
    o.est = 8'(est);
    return o;
  endfunction

  // Expected cycle-by-cycle outputs of one whole instruction, starting at its fetch
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, output int n);
    obs_t o;
    bit   exc;
    bit   known;
    int   start;
    start = expq.size();
    exc   = 0;
    expq.push_back(blank(1));
    for (int k = 0; k < MW; k++) begin
      o = blank(2); o.srcb = 2'b01;
      if (k == MW - 1) begin o.irw = 1; o.loads = 6'b100000; end
      expq.push_back(o);
    end
    o = blank(3); o.loads = 6'b001110; o.srcb = 2'b11; expq.push_back(o);
    case (op)
      6'h00: begin
        known = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25);
        o = blank(8); o.srca = 1; o.loads = 6'b000010;
        o.aluop = (fn == 6'h22) ? 3'd1 : (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd0;
        expq.push_back(o);
        if (!known || (OVF_EXC && ov && (fn == 6'h20 || fn == 6'h22))) exc = 1;
        else begin o = blank(9); o.regw = 1; o.regdst = 1; expq.push_back(o); end
      end
      6'h08: begin
        o = blank(10); o.srca = 1; o.srcb = 2'b10; o.loads = 6'b000010; expq.push_back(o);
        if (OVF_EXC && ov) exc = 1;
        else begin o = blank(11); o.regw = 1; expq.push_back(o); end
      end
      6'h23, 6'h2B: begin
        o = blank(4); o.srca = 1; o.srcb = 2'b10; o.loads = 6'b000010; expq.push_back(o);
        if (op == 6'h23) begin
          for (int k = 0; k < MW; k++) begin
            o = blank(5); o.iord = 1;
            if (k == MW - 1) o.loads = 6'b010000;
            expq.push_back(o);
          end
          o = blank(6); o.regw = 1; o.memtoreg = 1; expq.push_back(o);
        end else begin
          o = blank(7); o.iord = 1; o.wr = 1; expq.push_back(o);
        end
      end
      6'h04, 6'h05: begin
        o = blank(12); o.srca = 1; o.aluop = 3'd1; o.pcsrc = 2'b01;
        o.loads[5] = (op == 6'h04) ? z : ~z;
        expq.push_back(o);
      end
      6'h02: begin
        o = blank(13); o.pcsrc = 2'b10; o.loads = 6'b100000; expq.push_back(o);
      end
      default: exc = 1;
    endcase
    if (exc) begin
      o = blank(14); o.srcb = 2'b01; o.aluop = 3'd1; o.loads = 6'b000001; expq.push_back(o);
      o = blank(15); o.pcsrc = 2'b11; o.loads = 6'b100000; expq.push_back(o);
    end
    n = expq.size() - start;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge Clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle t=%0t estado got %0d want %0d, vector got %h want %h",
                   $time, act.est, e.est, act, e);
        end
      end
    end
  end

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov);
    int n;
    Opcode = op; Funct = fn; Zero = z; Overflow = ov;
    model_instr(op, fn, z, ov, n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [5:0] op_tab[9] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};
  logic [5:0] fn_tab[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h3F};

  initial begin : stim
    bit found;
    logic [5:0] op, fn;
    repeat (3) begin
      @(posedge Clk); #1;
      expq.push_back(blank(0));
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    expq.push_back(blank(0));
    @(posedge Clk); #1;

    run_instr(6'h00, 6'h20, 1'b0, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0, 1'b1);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1);
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      op = (($urandom_range(0, 7)) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 8)];
      fn = (($urandom_range(0, 5)) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom), 1'($urandom));
    end

    @(negedge Clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d want 0", expq.size());
    end

    // Reset asserted in the middle of a store write
    Opcode = 6'h2B;
    found  = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge Clk);
      if (Estado == 8'd7) found = 1;
    end
    checks++;
    if (!found || wr !== 1'b1) begin
      errors++;
      $display("FAIL sw_reach found %0d wr %b want 1", found, wr);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b0 || Estado !== 8'd0 || Loads !== 6'd0 || IorD !== 1'b0) begin
      errors++;
      $display("FAIL sw_abort wr %b estado %0d loads %b want 0 0 0", wr, Estado, Loads);
    end
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (Estado !== 8'd0) begin
      errors++;
      $display("FAIL post_reset estado %0d want 0", Estado);
    end

    // Reset asserted while sitting in the fetch wait
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge Clk);
      if (Estado == 8'd2) found = 1;
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (!found || Estado !== 8'd0 || act !== blank(0)) begin
      errors++;
      $display("FAIL wait_abort found %0d estado %0d vector %h want 0", found, Estado, act);
    end
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (Estado !== 8'd1) begin
      errors++;
      $display("FAIL refetch estado %0d want 1", Estado);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
